ex_stage_mdu: RTL and testbench
===============================

// Module: ex_stage_mdu
// PURPOSE
//  Parametrised execute stage plus EX/MEM pipeline register. Adds an iterative RV32M multiply/divide unit beside the ALU.
//  Sits between ID/EX and the memory stage.
//  Selects forwarded operands from NFWD sources and runs single-cycle ALU ops or multi-cycle M ops.
//  Raises ex_busy to the hazard unit while an M op is in flight.
// PARAMETERS
//  XLEN   32  datapath width (>=8)
//  NFWD   2   forwarding sources; source 0 = MEM stage, source 1 = WB stage
//  SELW   2   forwarding select width, must satisfy 2**SELW >= NFWD+1
// PORTS
//  clk            in   1          clock, rising edge
//  reset          in   1          synchronous, active-high
//  in_valid       in   1          ID/EX slot holds a real instruction
//  ctl_in         in   5          {MemtoReg,RegWrite,MemRead,MemWrite,Branch}
//  alu_src        in   1          1: operand B = imm_in
//  alu_op         in   2          ALUOp encoding as decoded by ID
//  funct7/funct3  in   7/3        instruction function fields
//  rd_in          in   5          destination register
//  pc_in,imm_in   in   XLEN       PC and immediate
//  rs1_data       in   XLEN       register-file read data, port 1
//  rs2_data       in   XLEN       register-file read data, port 2
//  fwd_data       in   NFWD*XLEN  forwarding buses; source k at [k*XLEN +: XLEN]
//  fwd_sel_a/b    in   SELW       0: rs data; k+1: fwd_data source k
//  stall_in       in   1          downstream hold; EX/MEM register keeps its value
//  flush          in   1          kill the EX slot and any in-flight M op
//  ex_busy        out  1          M op in progress; upstream must hold ID/EX
//  out_valid      out  1          EX/MEM slot valid
//  ctl_out        out  5          registered ctl_in; forced to 0 when slot is invalid
//  rd_out         out  5          registered destination register
//  pc_out         out  XLEN       registered PC
//  result_out     out  XLEN       ALU or M-unit result
//  rs2_out        out  XLEN       forwarded operand B before the imm mux (store data)
//  zero_out       out  1          result_out == 0
// BEHAVIOUR
//  Reset: all outputs 0, FSM to IDLE, in-flight M op discarded.
//  Operand mux: fwd_sel values greater than NFWD select rs data.
//  M op: alu_op==2'b10 and funct7==7'b0000001. All other ops are single-cycle.
//  Single-cycle op: registered on the next edge; out_valid = in_valid.
//  FSM states: IDLE, MUL, DIV, DONE.
//   IDLE->MUL/DIV on a valid M op with no flush.
//     Capture both operands, ctl, rd and pc on this edge; ex_busy rises combinationally in that cycle.
//   MUL and DIV run a radix-2 shift loop for exactly XLEN cycles, then enter DONE.
//   DONE: write the EX/MEM register with out_valid=1. ex_busy drops in this cycle; return to IDLE.
//  M-op latency: the result is visible on outputs XLEN+2 edges after issue.
//  While ex_busy=1, the EX/MEM register loads a bubble each edge (out_valid=0, ctl_out=0), unless stall_in=1.
//  mul/mulh/mulhsu/mulhu: low or high XLEN bits of the 2*XLEN product.
//   Signedness follows funct3 per RV32M.
//  div/rem: signed per RV32M. divu/remu: unsigned.
//  Division corner cases:
//   Divide by zero: quotient = all ones; remainder = dividend.
//   MIN / -1: quotient = MIN; remainder = 0.
//  stall_in=1:
//   All EX/MEM outputs hold.
//   FSM continues to run but waits in DONE until stall_in=0.
//   ex_busy stays 1 while waiting in DONE.
//  flush=1 (has priority over stall_in):
//   Next edge: out_valid=0, ctl_out=0, FSM to IDLE.
//   ex_busy drops combinationally in the flush cycle.
//  Simultaneous flush and issue: the issue is dropped.
//  reset asserted mid-op: same effect as flush, and all data outputs are also zeroed.
// CONFIGURATION
//  EX_MDU_DIV_EN defined: DIV state and div/divu/rem/remu are implemented as above.
//  EX_MDU_DIV_EN undefined:
//   Divide/remainder ops complete in a single cycle with result_out=0 and out_valid=in_valid.
//   The DIV state is not present.
// TESTING
//  add: rs1=5, rs2=7, fwd_sel=0 -> next edge result_out=12, out_valid=1, zero_out=0.
//  fwd_sel_a=1 with fwd_data[0]=100, imm=-1, alu_src=1 -> result_out=99.
//  mulhu 0xFFFFFFFF*0xFFFFFFFF:
//   -> ex_busy high for 33 cycles, then result_out=0xFFFFFFFE, one valid slot, bubbles before it.
//  div 7/0 -> 0xFFFFFFFF.
//  rem 0x80000000/-1 -> 0.
//  divu 100/7 -> 14 after XLEN+2 edges (all with EX_MDU_DIV_EN defined).
//  Issue mul, assert flush on cycle 10 -> ex_busy=0 that cycle; out_valid stays 0; the next add completes normally.
//  stall_in=1 across the DONE cycle of a mul -> outputs hold; result appears on the first edge after stall_in falls.

Source files
------------

// File: rtl/ex_stage_mdu.sv
// Execute stage: forwarding muxes, single-cycle ALU, iterative RV32M multiply/divide unit, EX/MEM register.
// Define EX_MDU_DIV_EN to build the divider; otherwise div/rem ops complete in one cycle with result 0.
module ex_stage_mdu #(
    parameter int XLEN = 32,
    parameter int NFWD = 2,
    parameter int SELW = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [4:0]           ctl_in,
    input  logic                 alu_src,
    input  logic [1:0]           alu_op,
    input  logic [6:0]           funct7,
    input  logic [2:0]           funct3,
    input  logic [4:0]           rd_in,
    input  logic [XLEN-1:0]      pc_in,
    input  logic [XLEN-1:0]      imm_in,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic [SELW-1:0]      fwd_sel_a,
    input  logic [SELW-1:0]      fwd_sel_b,
    input  logic                 stall_in,
    input  logic                 flush,
    output logic                 ex_busy,
    output logic                 out_valid,
    output logic [4:0]           ctl_out,
    output logic [4:0]           rd_out,
    output logic [XLEN-1:0]      pc_out,
    output logic [XLEN-1:0]      result_out,
    output logic [XLEN-1:0]      rs2_out,
    output logic                 zero_out
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef EX_MDU_DIV_EN
        DIV  = 2'd2,
`endif
        DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, mc_q, mc_d, m_pc_q, m_pc_d, m_b_q, m_b_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
    logic [4:0]        m_ctl_q, m_ctl_d, m_rd_q, m_rd_d, ctl_q, ctl_d, rd_q, rd_d;
    logic              valid_q, valid_d, zero_q, zero_d;
    logic [XLEN-1:0]   pc_q, pc_d, result_q, result_d, rs2_q, rs2_d;

    logic [XLEN-1:0]   opa, opb, opb_alu, alu_res, mag_a, mag_b, quo, rem, m_res;
    logic [2*XLEN-1:0] prod;
    logic [XLEN:0]     mul_sum;
    logic              is_m, m_issues, issue, sgn_a, sgn_b, neg_a, neg_b;

    // NOTE: every variable driven in always_comb gets a default first; a missed branch would infer a latch.
    always_comb begin
        opa = rs1_data;
        opb = rs2_data;
        for (int k = 0; k < NFWD; k++) begin
            if (fwd_sel_a == SELW'(k + 1)) opa = fwd_data[k*XLEN +: XLEN];
            if (fwd_sel_b == SELW'(k + 1)) opb = fwd_data[k*XLEN +: XLEN];
        end
    end

    assign opb_alu = alu_src ? imm_in : opb;
    assign is_m    = (alu_op == 2'b10) && (funct7 == 7'b0000001);

    always_comb begin
        alu_res = '0;
        case (alu_op)
            2'b00: alu_res = opa + opb_alu;
            2'b01: alu_res = opa - opb_alu;
            default: begin
                case (funct3)
                    3'b000: alu_res = (alu_op == 2'b10 && funct7[5]) ? opa - opb_alu : opa + opb_alu;
                    3'b001: alu_res = opa << opb_alu[SHW-1:0];
                    3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb_alu)};
                    3'b011: alu_res = {{(XLEN-1){1'b0}}, opa < opb_alu};
                    3'b100: alu_res = opa ^ opb_alu;
                    3'b101: alu_res = funct7[5] ? XLEN'($signed(opa) >>> opb_alu[SHW-1:0])
                                                : opa >> opb_alu[SHW-1:0];
                    3'b110: alu_res = opa | opb_alu;
                    default: alu_res = opa & opb_alu;
                endcase
            end
        endcase
        // Only div/rem reach here as M ops when the divider is left out.
        if (is_m) alu_res = '0;
    end

`ifdef EX_MDU_DIV_EN
    assign m_issues = is_m;
    logic [XLEN:0] rem_sh, diff;
    assign rem_sh = {hi_q, lo_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, mc_q};
`else
    assign m_issues = is_m && !funct3[2];
`endif

    assign issue   = in_valid && m_issues && !flush && !reset && (state_q == IDLE);
    assign sgn_a   = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign sgn_b   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign neg_a   = sgn_a && opa[XLEN-1];
    assign neg_b   = sgn_b && opb[XLEN-1];
    assign mag_a   = neg_a ? -opa : opa;
    assign mag_b   = neg_b ? -opb : opb;
    assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mc_q : {XLEN{1'b0}})};

    always_comb begin
        ex_busy = 1'b0;
        case (state_q)
            IDLE:    ex_busy = issue;
            DONE:    ex_busy = stall_in;
            default: ex_busy = 1'b1;
        endcase
        if (flush || reset) ex_busy = 1'b0;
    end

    // Shift loops work on magnitudes; signs are restored here from the flags captured at issue.
    always_comb begin
        prod = {hi_q, lo_q};
        if (neg_res_q) prod = -prod;
        quo = neg_res_q ? -lo_q : lo_q;
        if (dz_q) quo = '1;
        rem = neg_rem_q ? -hi_q : hi_q;
        case (f3_q)
            3'b000:                 m_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: m_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         m_res = quo;
            default:                m_res = rem;
        endcase
    end

    always_comb begin
        state_d = state_q;   cnt_d = cnt_q;       hi_d = hi_q;     lo_d = lo_q;   mc_d = mc_q;
        f3_d = f3_q;         neg_res_d = neg_res_q; neg_rem_d = neg_rem_q; dz_d = dz_q;
        m_ctl_d = m_ctl_q;   m_rd_d = m_rd_q;     m_pc_d = m_pc_q; m_b_d = m_b_q;
        valid_d = valid_q;   ctl_d = ctl_q;       rd_d = rd_q;     pc_d = pc_q;
        result_d = result_q; rs2_d = rs2_q;       zero_d = zero_q;

        case (state_q)
            IDLE: begin
                if (issue) begin
                    cnt_d     = '0;
                    hi_d      = '0;
                    lo_d      = funct3[2] ? mag_a : mag_b;
                    mc_d      = funct3[2] ? mag_b : mag_a;
                    f3_d      = funct3;
                    neg_res_d = neg_a ^ neg_b;
                    neg_rem_d = neg_a;
                    dz_d      = (opb == '0);
                    m_ctl_d   = ctl_in;
                    m_rd_d    = rd_in;
                    m_pc_d    = pc_in;
                    m_b_d     = opb;
`ifdef EX_MDU_DIV_EN
                    state_d   = funct3[2] ? DIV : MUL;
`else
                    state_d   = MUL;
`endif
                end
            end
            MUL: begin
                hi_d  = mul_sum[XLEN:1];
                lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
`ifdef EX_MDU_DIV_EN
            DIV: begin
                hi_d  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
                lo_d  = {lo_q[XLEN-2:0], !diff[XLEN]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
`endif
            DONE:    if (!stall_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;

        if (flush) begin
            valid_d = 1'b0;
            ctl_d   = '0;
        end else if (stall_in) begin
            valid_d = valid_q;
        end else if (state_q == DONE) begin
            valid_d  = 1'b1;
            ctl_d    = m_ctl_q;
            rd_d     = m_rd_q;
            pc_d     = m_pc_q;
            result_d = m_res;
            rs2_d    = m_b_q;
            zero_d   = (m_res == '0);
        end else if (ex_busy) begin
            valid_d = 1'b0;
            ctl_d   = '0;
        end else begin
            valid_d  = in_valid;
            ctl_d    = in_valid ? ctl_in : 5'd0;
            rd_d     = rd_in;
            pc_d     = pc_in;
            result_d = alu_res;
            rs2_d    = opb;
            zero_d   = (alu_res == '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE; cnt_q <= '0; hi_q <= '0; lo_q <= '0; mc_q <= '0;
            f3_q <= '0; neg_res_q <= 1'b0; neg_rem_q <= 1'b0; dz_q <= 1'b0;
            m_ctl_q <= '0; m_rd_q <= '0; m_pc_q <= '0; m_b_q <= '0;
            valid_q <= 1'b0; ctl_q <= '0; rd_q <= '0; pc_q <= '0;
            result_q <= '0; rs2_q <= '0; zero_q <= 1'b0;
        end else begin
            state_q <= state_d; cnt_q <= cnt_d; hi_q <= hi_d; lo_q <= lo_d; mc_q <= mc_d;
            f3_q <= f3_d; neg_res_q <= neg_res_d; neg_rem_q <= neg_rem_d; dz_q <= dz_d;
            m_ctl_q <= m_ctl_d; m_rd_q <= m_rd_d; m_pc_q <= m_pc_d; m_b_q <= m_b_d;
            valid_q <= valid_d; ctl_q <= ctl_d; rd_q <= rd_d; pc_q <= pc_d;
            result_q <= result_d; rs2_q <= rs2_d; zero_q <= zero_d;
        end
    end

    assign out_valid  = valid_q;
    assign ctl_out    = ctl_q;
    assign rd_out     = rd_q;
    assign pc_out     = pc_q;
    assign result_out = result_q;
    assign rs2_out    = rs2_q;
    assign zero_out   = zero_q;

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed self-checking bench for ex_stage_mdu (XLEN=32, NFWD=2, SELW=2).
// Divide tests follow EX_MDU_DIV_EN the same way the design does.
module tb_ex_stage_mdu;
    localparam int XLEN = 32;

    logic              clk, reset, in_valid, alu_src, stall_in, flush;
    logic [4:0]        ctl_in, rd_in;
    logic [1:0]        alu_op;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic [31:0]       pc_in, imm_in, rs1_data, rs2_data;
    logic [63:0]       fwd_data;
    logic [1:0]        fwd_sel_a, fwd_sel_b;
    logic              ex_busy, out_valid, zero_out;
    logic [4:0]        ctl_out, rd_out;
    logic [31:0]       pc_out, result_out, rs2_out;

    int errors = 0;
    int checks = 0;

    ex_stage_mdu #(.XLEN(32), .NFWD(2), .SELW(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .ctl_in(ctl_in), .alu_src(alu_src),
        .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .rd_in(rd_in), .pc_in(pc_in),
        .imm_in(imm_in), .rs1_data(rs1_data), .rs2_data(rs2_data), .fwd_data(fwd_data),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall_in(stall_in), .flush(flush),
        .ex_busy(ex_busy), .out_valid(out_valid), .ctl_out(ctl_out), .rd_out(rd_out),
        .pc_out(pc_out), .result_out(result_out), .rs2_out(rs2_out), .zero_out(zero_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; ctl_in = '0; alu_src = 1'b0; alu_op = '0; funct7 = '0; funct3 = '0;
        rd_in = '0; pc_in = '0; imm_in = '0; rs1_data = '0; rs2_data = '0;
        fwd_data = '0; fwd_sel_a = '0; fwd_sel_b = '0;
    endtask

    task automatic op(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                      input logic [31:0] pc);
        idle();
        in_valid = 1'b1; ctl_in = 5'b01000; alu_op = aop; funct7 = f7; funct3 = f3;
        rs1_data = a; rs2_data = b; rd_in = rd; pc_in = pc;
    endtask

    // Holds the M op in ID/EX while ex_busy is high, then releases it and checks the result slot.
    task automatic run_mop(input string tag, input logic [31:0] exp);
        int n;
        int bad;
        n = 0;
        bad = 0;
        #1;
        while (ex_busy === 1'b1 && n < 100) begin
            tick();
            n++;
            if (out_valid !== 1'b0 || ctl_out !== 5'd0) bad++;
        end
        check({tag, " busy cycles"}, 64'(n), 64'(XLEN + 1));
        check({tag, " bubbles"}, 64'(bad), 64'd0);
        idle();
        tick();
        check({tag, " valid"}, 64'(out_valid), 64'd1);
        check({tag, " result"}, 64'(result_out), 64'(exp));
        tick();
        check({tag, " single slot"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int cnt;
        reset = 1'b1; stall_in = 1'b0; flush = 1'b0;
        idle();
        tick();
        tick();
        check("rst valid", 64'(out_valid), 64'd0);
        check("rst ctl", 64'(ctl_out), 64'd0);
        check("rst result", 64'(result_out), 64'd0);
        check("rst zero", 64'(zero_out), 64'd0);
        check("rst busy", 64'(ex_busy), 64'd0);
        check("rst pc", 64'(pc_out), 64'd0);
        reset = 1'b0;

        // add from register file
        op(2'b10, 7'h00, 3'b000, 32'd5, 32'd7, 5'd3, 32'h100);
        tick();
        check("add result", 64'(result_out), 64'd12);
        check("add valid", 64'(out_valid), 64'd1);
        check("add zero", 64'(zero_out), 64'd0);
        check("add ctl", 64'(ctl_out), 64'h08);
        check("add rd", 64'(rd_out), 64'd3);
        check("add pc", 64'(pc_out), 64'h100);
        check("add rs2", 64'(rs2_out), 64'd7);

        // forwarded A from MEM source plus immediate
        op(2'b00, 7'h00, 3'b000, 32'd5, 32'h55, 5'd4, 32'h104);
        fwd_sel_a = 2'd1; fwd_data = {32'd1, 32'd100}; alu_src = 1'b1; imm_in = 32'hFFFF_FFFF;
        tick();
        check("fwd imm result", 64'(result_out), 64'd99);
        check("fwd imm rs2", 64'(rs2_out), 64'h55);

        // out-of-range select falls back to rs1; B from WB source
        op(2'b01, 7'h00, 3'b000, 32'd10, 32'd3, 5'd5, 32'h108);
        fwd_sel_a = 2'd3; fwd_sel_b = 2'd2; fwd_data = {32'd10, 32'd100};
        tick();
        check("sub fwd result", 64'(result_out), 64'd0);
        check("sub fwd zero", 64'(zero_out), 64'd1);
        check("sub fwd rs2", 64'(rs2_out), 64'd10);

        op(2'b10, 7'h20, 3'b101, 32'h8000_0000, 32'd4, 5'd6, 32'h10c);
        tick();
        check("sra", 64'(result_out), 64'hF800_0000);

        op(2'b10, 7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'h110);
        tick();
        check("slt", 64'(result_out), 64'd1);

        idle();
        ctl_in = 5'b11111;
        tick();
        check("bubble valid", 64'(out_valid), 64'd0);
        check("bubble ctl", 64'(ctl_out), 64'd0);

        // multiplies
        op(2'b10, 7'h01, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h200);
        run_mop("mulhu", 32'hFFFF_FFFE);
        check("mulhu rd", 64'(rd_out), 64'd0);
        op(2'b10, 7'h01, 3'b000, 32'hFFFF_FFFD, 32'd7, 5'd8, 32'h204);
        run_mop("mul", 32'hFFFF_FFEB);
        op(2'b10, 7'h01, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd8, 32'h208);
        run_mop("mulh", 32'h4000_0000);
        op(2'b10, 7'h01, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'h20c);
        run_mop("mulhsu", 32'hFFFF_FFFF);

`ifdef EX_MDU_DIV_EN
        op(2'b10, 7'h01, 3'b100, 32'd7, 32'd0, 5'd9, 32'h300);
        run_mop("div by zero", 32'hFFFF_FFFF);
        op(2'b10, 7'h01, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h304);
        run_mop("rem min/-1", 32'd0);
        op(2'b10, 7'h01, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h308);
        run_mop("div min/-1", 32'h8000_0000);
        op(2'b10, 7'h01, 3'b101, 32'd100, 32'd7, 5'd9, 32'h30c);
        run_mop("divu", 32'd14);
        op(2'b10, 7'h01, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'h310);
        run_mop("div neg", 32'hFFFF_FFFD);
        op(2'b10, 7'h01, 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'h314);
        run_mop("rem neg", 32'hFFFF_FFFF);
`else
        op(2'b10, 7'h01, 3'b100, 32'd7, 32'd3, 5'd9, 32'h300);
        #1;
        check("nodiv busy", 64'(ex_busy), 64'd0);
        tick();
        check("nodiv valid", 64'(out_valid), 64'd1);
        check("nodiv result", 64'(result_out), 64'd0);
        check("nodiv zero", 64'(zero_out), 64'd1);
`endif

        // flush in cycle 10 of a multiply
        op(2'b10, 7'h01, 3'b000, 32'd3, 32'd4, 5'd10, 32'h400);
        #1;
        check("flush issue busy", 64'(ex_busy), 64'd1);
        repeat (9) tick();
        flush = 1'b1;
        #1;
        check("flush busy drop", 64'(ex_busy), 64'd0);
        tick();
        flush = 1'b0;
        idle();
        check("flush valid", 64'(out_valid), 64'd0);
        check("flush ctl", 64'(ctl_out), 64'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid !== 1'b0 || ex_busy !== 1'b0) cnt++;
        end
        check("flush no late result", 64'(cnt), 64'd0);
        op(2'b10, 7'h00, 3'b000, 32'd1, 32'd2, 5'd11, 32'h404);
        tick();
        check("post flush add", 64'(result_out), 64'd3);
        check("post flush valid", 64'(out_valid), 64'd1);

        // downstream stall across DONE
        op(2'b10, 7'h01, 3'b000, 32'd6, 32'd7, 5'd12, 32'h500);
        stall_in = 1'b1;
        #1;
        check("stall issue busy", 64'(ex_busy), 64'd1);
        repeat (33) tick();
        check("stall done busy", 64'(ex_busy), 64'd1);
        check("stall hold result", 64'(result_out), 64'd3);
        check("stall hold valid", 64'(out_valid), 64'd1);
        tick();
        check("stall wait busy", 64'(ex_busy), 64'd1);
        check("stall wait result", 64'(result_out), 64'd3);
        stall_in = 1'b0;
        #1;
        check("stall release busy", 64'(ex_busy), 64'd0);
        idle();
        tick();
        check("stall mul result", 64'(result_out), 64'd42);
        check("stall mul valid", 64'(out_valid), 64'd1);
        check("stall mul rd", 64'(rd_out), 64'd12);
        check("stall mul pc", 64'(pc_out), 64'h500);

        // reset in the middle of a multiply
        op(2'b10, 7'h01, 3'b000, 32'd6, 32'd7, 5'd13, 32'h600);
        repeat (5) tick();
        reset = 1'b1;
        #1;
        check("midrst busy", 64'(ex_busy), 64'd0);
        tick();
        check("midrst valid", 64'(out_valid), 64'd0);
        check("midrst result", 64'(result_out), 64'd0);
        check("midrst rd", 64'(rd_out), 64'd0);
        check("midrst pc", 64'(pc_out), 64'd0);
        reset = 1'b0;
        op(2'b10, 7'h00, 3'b100, 32'hF0, 32'h0F, 5'd14, 32'h604);
        tick();
        check("post rst xor", 64'(result_out), 64'hFF);
        check("post rst busy", 64'(ex_busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
